seq_pattern_transmitter: RTL and testbench



---
 rtl/seq_pattern_transmitter_if.sv | 33 +++
 rtl/seq_pattern_transmitter.sv | 138 +++++++++++++
 tb/tb_seq_pattern_transmitter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_transmitter_if.sv
// Handshake and data bundle for seq_pattern_transmitter.
//   master: the side that requests transfers (drives start, pattern,
//           repeat_cnt, gap, abort; observes the serial stream and status).
//   slave : the transmitter itself.
// Signals:
//   start, pattern[PAT_W], repeat_cnt[CNT_W], gap[GAP_W], abort -> slave
//   dout, dout_valid, busy, done, patterns_sent[CNT_W]           -> master
interface seq_pattern_transmitter_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap;
    logic             abort;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] patterns_sent;

    modport master (
        output start, pattern, repeat_cnt, gap, abort,
        input  dout, dout_valid, busy, done, patterns_sent
    );

    modport slave (
        input  start, pattern, repeat_cnt, gap, abort,
        output dout, dout_valid, busy, done, patterns_sent
    );
endinterface

// File: rtl/seq_pattern_transmitter.sv
// Serial pattern source. Shifts a PAT_W-bit pattern out MSB-first, one bit
// per clock, repeating it repeat_cnt times with `gap` idle cycles between
// repetitions. Every output is a register (Moore style).
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - seq_pattern_transmitter_if.slave:
//          start/pattern/repeat_cnt/gap/abort in,
//          dout/dout_valid/busy/done/patterns_sent out
module seq_pattern_transmitter #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    seq_pattern_transmitter_if.slave     bus
);
    localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           state_reg;
    logic [PAT_W-1:0] pat_reg;      // latched pattern, reloaded every repetition
    logic [PAT_W-1:0] shift_reg;    // bits still to send, MSB-aligned
    logic [CNT_W-1:0] rep_reg;
    logic [GAP_W-1:0] gap_reg;
    logic [BIT_W-1:0] bit_cnt_reg;
    logic [GAP_W-1:0] gap_cnt_reg;  // counts down gap-1 .. 0
    logic [CNT_W-1:0] sent_reg;
    logic             dout_reg;
    logic             valid_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [CNT_W-1:0] sent_next;
    assign sent_next = sent_reg + 1'b1;

    assign bus.dout          = dout_reg;
    assign bus.dout_valid    = valid_reg;
    assign bus.busy          = busy_reg;
    assign bus.done          = done_reg;
    assign bus.patterns_sent = sent_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            pat_reg     <= '0;
            shift_reg   <= '0;
            rep_reg     <= '0;
            gap_reg     <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            sent_reg    <= '0;
            dout_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        sent_reg <= '0;
                        if (bus.repeat_cnt != '0) begin
                            pat_reg     <= bus.pattern;
                            rep_reg     <= bus.repeat_cnt;
                            gap_reg     <= bus.gap;
                            shift_reg   <= {bus.pattern[PAT_W-2:0], 1'b0};
                            bit_cnt_reg <= '0;
                            dout_reg    <= bus.pattern[PAT_W-1];
                            valid_reg   <= 1'b1;
                            busy_reg    <= 1'b1;
                            state_reg   <= SHIFT;
                        end else begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end

                SHIFT: begin
                    if (bus.abort) begin
                        dout_reg  <= 1'b0;
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (bit_cnt_reg == LAST_BIT) begin
                        sent_reg <= sent_next;
                        if (sent_next == rep_reg) begin
                            dout_reg  <= 1'b0;
                            valid_reg <= 1'b0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else if (gap_reg == '0) begin
                            // Back-to-back: next MSB appears with no bubble.
                            shift_reg   <= {pat_reg[PAT_W-2:0], 1'b0};
                            bit_cnt_reg <= '0;
                            dout_reg    <= pat_reg[PAT_W-1];
                        end else begin
                            gap_cnt_reg <= gap_reg - 1'b1;
                            dout_reg    <= 1'b0;
                            valid_reg   <= 1'b0;
                            state_reg   <= GAP;
                        end
                    end else begin
                        dout_reg    <= shift_reg[PAT_W-1];
                        shift_reg   <= {shift_reg[PAT_W-2:0], 1'b0};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end

                GAP: begin
                    if (bus.abort) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (gap_cnt_reg == '0) begin
                        shift_reg   <= {pat_reg[PAT_W-2:0], 1'b0};
                        bit_cnt_reg <= '0;
                        dout_reg    <= pat_reg[PAT_W-1];
                        valid_reg   <= 1'b1;
                        state_reg   <= SHIFT;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 1'b1;
                    end
                end

                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_pattern_transmitter.sv
module tb_seq_pattern_transmitter;
    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seq_pattern_transmitter_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

    seq_pattern_transmitter #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Moore "1000" detector fed by the serial stream (input forced 0 when
    // dout_valid is low); flag is decoded from the registered history.
    logic [3:0] det_hist;
    logic       det_flag;
    always @(posedge clk) begin
        if (rst) det_hist <= 4'b0;
        else     det_hist <= {det_hist[2:0], bus.dout & bus.dout_valid};
    end
    assign det_flag = (det_hist == 4'b1000);

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.pattern    = '0;
        bus.repeat_cnt = '0;
        bus.gap        = '0;
    endtask

    // Runs one transfer and compares every cycle after the start edge with a
    // reference stream built from the transfer rules.
    // stop_kind: 0 none, 1 abort during cycle stop_at, 2 rst during cycle stop_at.
    // noisy: pulse start and scramble inputs while the transfer is in flight.
    task automatic run_transfer(input string name, input logic [PAT_W-1:0] pat,
                                input int rep, input int gp, input int stop_at,
                                input int stop_kind, input bit noisy);
        bit e_dout[$];
        bit e_valid[$];
        bit e_busy[$];
        bit e_done[$];
        int e_sent[$];
        int done_idx;
        int limit;
        int after_sent;
        int nfail = 0;

        for (int r = 0; r < rep; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--) begin
                e_dout.push_back(pat[b]); e_valid.push_back(1'b1);
                e_busy.push_back(1'b1);   e_done.push_back(1'b0);
                e_sent.push_back(r);
            end
            if (r < rep - 1) begin
                for (int g = 0; g < gp; g++) begin
                    e_dout.push_back(1'b0); e_valid.push_back(1'b0);
                    e_busy.push_back(1'b1); e_done.push_back(1'b0);
                    e_sent.push_back(r + 1);
                end
            end
        end
        done_idx = e_done.size();
        e_dout.push_back(1'b0); e_valid.push_back(1'b0);
        e_busy.push_back(1'b0); e_done.push_back(1'b1);
        e_sent.push_back(rep);
        for (int k = 0; k < 2; k++) begin
            e_dout.push_back(1'b0); e_valid.push_back(1'b0);
            e_busy.push_back(1'b0); e_done.push_back(1'b0);
            e_sent.push_back(rep);
        end

        limit = done_idx;
        if (stop_kind != 0) begin
            limit = stop_at;
            after_sent = (stop_kind == 1) ? e_sent[stop_at] : 0;
            for (int i = stop_at + 1; i < e_done.size(); i++) begin
                e_dout[i] = 1'b0; e_valid[i] = 1'b0; e_busy[i] = 1'b0;
                e_done[i] = 1'b0; e_sent[i] = after_sent;
            end
        end

        bus.pattern    = pat;
        bus.repeat_cnt = CNT_W'(rep);
        bus.gap        = GAP_W'(gp);
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;

        for (int i = 0; i < e_done.size(); i++) begin
            bus.abort = (stop_kind == 1 && i == stop_at);
            rst       = (stop_kind == 2 && i == stop_at);
            if (noisy && i <= limit) begin
                bus.start      = $urandom_range(0, 1) == 1;
                bus.pattern    = PAT_W'($urandom);
                bus.repeat_cnt = CNT_W'($urandom);
                bus.gap        = GAP_W'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (bus.dout !== e_dout[i] || bus.dout_valid !== e_valid[i] ||
                bus.busy !== e_busy[i] || bus.done !== e_done[i] ||
                bus.patterns_sent !== CNT_W'(e_sent[i])) begin
                failures++;
                nfail++;
                $display("FAIL %s cyc=%0d got dout=%b valid=%b busy=%b done=%b sent=%0d exp dout=%b valid=%b busy=%b done=%b sent=%0d",
                         name, i, bus.dout, bus.dout_valid, bus.busy, bus.done, bus.patterns_sent,
                         e_dout[i], e_valid[i], e_busy[i], e_done[i], e_sent[i]);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        rst = 1'b0;
        $display("xfer %s pat=%b rep=%0d gap=%0d stop_kind=%0d stop_at=%0d cycles=%0d errors=%0d",
                 name, pat, rep, gp, stop_kind, stop_at, e_done.size(), nfail);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.repeat_cnt = 8'd3;
        bus.pattern = 4'b1111;
        bus.abort = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.dout !== 1'b0 || bus.dout_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.patterns_sent !== '0) begin
            failures++;
            $display("FAIL reset got dout=%b valid=%b busy=%b done=%b sent=%0d exp all 0",
                     bus.dout, bus.dout_valid, bus.busy, bus.done, bus.patterns_sent);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        $display("xfer reset done");
    endtask

    task automatic test_single();
        run_transfer("single", 4'b1000, 1, 0, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_transfer("back_to_back", 4'b1000, 3, 0, 0, 0, 1'b0);
    endtask

    task automatic test_gap();
        run_transfer("gap", 4'b1011, 2, 2, 0, 0, 1'b0);
    endtask

    task automatic test_zero_count();
        run_transfer("zero_count", 4'b1111, 0, 3, 0, 0, 1'b0);
    endtask

    task automatic test_abort();
        // Second bit of repetition 3: 4 bits + 1 gap per earlier repetition.
        run_transfer("abort", 4'b1000, 5, 1, 2 * 5 + 1, 1, 1'b0);
    endtask

    task automatic test_ignored_start();
        run_transfer("ignored_start", 4'b1101, 3, 2, 0, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        // First gap cycle of a repeat=4 transfer.
        run_transfer("reset_mid", 4'b1001, 4, 3, PAT_W, 2, 1'b0);
        run_transfer("after_reset", 4'b0110, 2, 1, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            logic [PAT_W-1:0] pat;
            int rep;
            int gp;
            int kind;
            int at;
            pat  = PAT_W'($urandom);
            rep  = $urandom_range(0, 4);
            gp   = $urandom_range(0, 3);
            kind = 0;
            at   = 0;
            if (rep > 0 && $urandom_range(0, 3) == 0) begin
                kind = $urandom_range(1, 2);
                at   = $urandom_range(0, rep * PAT_W + (rep - 1) * gp - 1);
            end
            run_transfer($sformatf("random%0d", t), pat, rep, gp, at, kind,
                         $urandom_range(0, 1) == 1);
        end
    endtask

    task automatic test_loopback();
        int det_count = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.pattern    = 4'b1000;
        bus.repeat_cnt = 8'd2;
        bus.gap        = 4'd0;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (det_flag === 1'b1) det_count++;
            checks++;
            if (det_flag !== ((i == 4) || (i == 8))) begin
                failures++;
                $display("FAIL loopback_det cyc=%0d got %b exp %b", i, det_flag, (i == 4) || (i == 8));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (det_count != 2) begin
            failures++;
            $display("FAIL loopback_count got %0d exp 2", det_count);
        end
        idle_inputs();
        $display("xfer loopback detections=%0d", det_count);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_zero_count();
        test_abort();
        test_ignored_start();
        test_reset_mid();
        test_random();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
